// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with saturating direction
// counters, EX-stage resolve, mispredict redirect and statistics.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [31:0]     if_pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [31:0]     ex_imm,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     ex_pc_four,
  output logic            ex_mispredict,
  output logic [31:0]     ex_redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_RST =
    CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [31:0]      w_pc32;
  logic [31:0]      w_br_tgt;
  logic [31:0]      w_target;
  logic             w_taken;
  logic             w_is_jal;
  logic             w_is_jalr;
  logic             w_is_cond;
  logic             w_ctrl;
  logic             w_alias;
  logic [31:0]      w_actual_next;
  logic [31:0]      w_pred_next;
  logic [CTR_W-1:0] w_ctr_cur;
  logic [CTR_W-1:0] w_ctr_base;
  logic [CTR_W-1:0] w_ctr_inc;
  logic [CTR_W-1:0] w_ctr_dec;
  logic             w_unused;

  assign w_unused = ^if_pc[1:0];

  // Fetch lookup reads registered state only: read-before-write
  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[PC_W-1:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] &&
                    (r_tag[w_if_idx] == w_if_tag);
  assign if_pred_taken  = w_if_hit && r_ctr[w_if_idx][CTR_W-1];
  assign if_pred_target = if_pred_taken ? r_target[w_if_idx] : '0;

  assign w_pc32     = {{(32-PC_W){1'b0}}, ex_pc};
  assign ex_pc_four = w_pc32 + 32'd4;
  assign w_br_tgt   = w_pc32 + ex_imm;

  assign w_is_jal  = !ex_branch &&  ex_jump;
  assign w_is_jalr =  ex_branch &&  ex_jump;
  assign w_is_cond =  ex_branch && !ex_jump;

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_br_tgt;
    unique case (1'b1)
      w_is_jal:  w_taken = 1'b1;
      w_is_jalr: begin
        w_taken  = 1'b1;
        w_target = {ex_alu_result[31:1], 1'b0};
      end
      w_is_cond: w_taken = ex_alu_result[0];
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_ctrl  = ex_valid && (ex_branch || ex_jump);
  assign w_alias = ex_valid && !ex_branch && !ex_jump &&
                   ex_pred_taken;

  assign w_actual_next = w_taken ? w_target : ex_pc_four;
  assign w_pred_next   = ex_pred_taken ? ex_pred_target : ex_pc_four;
  assign ex_mispredict = ex_valid &&
                         ((w_actual_next != w_pred_next) || w_alias);
  assign ex_redirect_pc = ex_mispredict ? w_actual_next : '0;

  assign w_ex_idx  = ex_pc[IDX_W+1:2];
  assign w_ex_tag  = ex_pc[PC_W-1:IDX_W+2];
  assign w_ex_hit  = r_valid[w_ex_idx] &&
                     (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ctr_cur = r_ctr[w_ex_idx];

  // A replaced or empty entry trains from the weakly-not-taken value
  assign w_ctr_base = w_ex_hit ? w_ctr_cur : CTR_RST;
  assign w_ctr_inc  = (w_ctr_base == CTR_MAX) ? w_ctr_base :
                      w_ctr_base + CTR_W'(1);
  assign w_ctr_dec  = (w_ctr_cur == '0) ? w_ctr_cur :
                      w_ctr_cur - CTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RST;
      end
    end else if (w_ctrl) begin
      if (ex_jump) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= w_target;
        r_ctr[w_ex_idx]    <= CTR_MAX;
      end else if (w_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= w_target;
        r_ctr[w_ex_idx]    <= w_ctr_inc;
      end else if (w_ex_hit) begin
        r_ctr[w_ex_idx]    <= w_ctr_dec;
      end
    end else if (w_alias) begin
      r_valid[w_ex_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (w_ctrl)        branch_count     <= branch_count + 32'd1;
      if (ex_mispredict) mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit.
// Inputs change on negedge; outputs sampled 1 time unit later.
module tb_branch_predict_unit;

  logic        clk;
  logic        reset_n;
  logic [8:0]  if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic        ex_branch;
  logic        ex_jump;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_result;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] ex_pc_four;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int nvec = 0;
  int nerr = 0;

  branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CTR_W(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_branch        (ex_branch),
    .ex_jump          (ex_jump),
    .ex_imm           (ex_imm),
    .ex_alu_result    (ex_alu_result),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_pc_four       (ex_pc_four),
    .ex_mispredict    (ex_mispredict),
    .ex_redirect_pc   (ex_redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [8:0] pc,
                       input logic br, input logic jp,
                       input logic [31:0] imm, input logic [31:0] alu,
                       input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_branch      = br;
    ex_jump        = jp;
    ex_imm         = imm;
    ex_alu_result  = alu;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 9'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_pc   = 9'h040;
    idle();
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0) begin
      $display("FAIL rst_pred got %0h exp 0", if_pred_taken); nerr++;
    end
    nvec++;
    if (if_pred_target !== 32'h0) begin
      $display("FAIL rst_tgt got %0h exp 0", if_pred_target); nerr++;
    end
    nvec++;
    if (branch_count !== 32'h0) begin
      $display("FAIL rst_bc got %0h exp 0", branch_count); nerr++;
    end
    nvec++;
    if (mispredict_count !== 32'h0) begin
      $display("FAIL rst_mc got %0h exp 0", mispredict_count); nerr++;
    end
    nvec++;
    if (ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'h0) begin
      $display("FAIL rst_mis got %0h/%0h exp 0/0",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
  endtask

  task automatic test_branch_taken();
    @(negedge clk);
    drive(1'b1, 9'h010, 1'b1, 1'b0, 32'h20, 32'h1, 1'b0, 32'h0);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h30) begin
      $display("FAIL bt_mis got %0h/%0h exp 1/30",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    nvec++;
    if (ex_pc_four !== 32'h14) begin
      $display("FAIL bt_pc4 got %0h exp 14", ex_pc_four); nerr++;
    end
    @(negedge clk);
    idle();
    if_pc = 9'h010;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h30) begin
      $display("FAIL bt_look got %0h/%0h exp 1/30",
               if_pred_taken, if_pred_target); nerr++;
    end
    nvec++;
    if (branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
      $display("FAIL bt_cnt got %0d/%0d exp 1/1",
               branch_count, mispredict_count); nerr++;
    end
  endtask

  task automatic test_branch_not_taken();
    @(negedge clk);
    drive(1'b1, 9'h010, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h14) begin
      $display("FAIL bnt_mis got %0h/%0h exp 1/14",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
      $display("FAIL bnt_look got %0h/%0h exp 0/0",
               if_pred_taken, if_pred_target); nerr++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 9'h010, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
      #1;
      nvec++;
      if (ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'h0) begin
        $display("FAIL bnt_sat%0d_mis got %0h/%0h exp 0/0", i,
                 ex_mispredict, ex_redirect_pc); nerr++;
      end
      @(negedge clk);
      idle();
      #1;
      nvec++;
      if (if_pred_taken !== 1'b0) begin
        $display("FAIL bnt_sat%0d_look got %0h exp 0", i,
                 if_pred_taken); nerr++;
      end
    end
    // counter at 0 -> one taken gives 1, still predicts not-taken
    @(negedge clk);
    drive(1'b1, 9'h010, 1'b1, 1'b0, 32'h20, 32'h1, 1'b0, 32'h0);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h30) begin
      $display("FAIL bnt_up_mis got %0h/%0h exp 1/30",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0) begin
      $display("FAIL bnt_up_look got %0h exp 0", if_pred_taken); nerr++;
    end
    nvec++;
    if (branch_count !== 32'd6 || mispredict_count !== 32'd3) begin
      $display("FAIL bnt_cnt got %0d/%0d exp 6/3",
               branch_count, mispredict_count); nerr++;
    end
  endtask

  task automatic test_jump();
    @(negedge clk);
    drive(1'b1, 9'h020, 1'b1, 1'b1, 32'h0, 32'h107, 1'b0, 32'h0);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h106) begin
      $display("FAIL jalr_mis got %0h/%0h exp 1/106",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    idle();
    if_pc = 9'h020;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h106) begin
      $display("FAIL jalr_look got %0h/%0h exp 1/106",
               if_pred_taken, if_pred_target); nerr++;
    end
    drive(1'b1, 9'h1F0, 1'b0, 1'b1, 32'hFFFF_FE0C, 32'h0, 1'b0, 32'h0);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'hFFFF_FFFC) begin
      $display("FAIL jal_mis got %0h/%0h exp 1/fffffffc",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    nvec++;
    if (ex_pc_four !== 32'h1F4) begin
      $display("FAIL jal_pc4 got %0h exp 1f4", ex_pc_four); nerr++;
    end
    @(negedge clk);
    idle();
    if_pc = 9'h1F0;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'hFFFF_FFFC) begin
      $display("FAIL jal_look got %0h/%0h exp 1/fffffffc",
               if_pred_taken, if_pred_target); nerr++;
    end
    nvec++;
    if (branch_count !== 32'd8 || mispredict_count !== 32'd5) begin
      $display("FAIL jmp_cnt got %0d/%0d exp 8/5",
               branch_count, mispredict_count); nerr++;
    end
  endtask

  task automatic test_alias();
    @(negedge clk);
    drive(1'b1, 9'h050, 1'b1, 1'b0, 32'h40, 32'h1, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    if_pc = 9'h050;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h90) begin
      $display("FAIL al_train got %0h/%0h exp 1/90",
               if_pred_taken, if_pred_target); nerr++;
    end
    if_pc = 9'h010;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0) begin
      $display("FAIL al_evict got %0h exp 0", if_pred_taken); nerr++;
    end
    drive(1'b1, 9'h050, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h90);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h54) begin
      $display("FAIL al_mis got %0h/%0h exp 1/54",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    idle();
    if_pc = 9'h050;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
      $display("FAIL al_inval got %0h/%0h exp 0/0",
               if_pred_taken, if_pred_target); nerr++;
    end
    drive(1'b1, 9'h110, 1'b1, 1'b0, 32'h10, 32'h1, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    if_pc = 9'h110;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h120) begin
      $display("FAIL al_repl got %0h/%0h exp 1/120",
               if_pred_taken, if_pred_target); nerr++;
    end
    nvec++;
    if (branch_count !== 32'd10 || mispredict_count !== 32'd8) begin
      $display("FAIL al_cnt got %0d/%0d exp 10/8",
               branch_count, mispredict_count); nerr++;
    end
  endtask

  task automatic test_no_update();
    @(negedge clk);
    drive(1'b1, 9'h030, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'h0) begin
      $display("FAIL nop_mis got %0h/%0h exp 0/0",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    drive(1'b0, 9'h030, 1'b1, 1'b0, 32'h8, 32'h1, 1'b0, 32'h0);
    #1;
    nvec++;
    if (ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'h0) begin
      $display("FAIL inv_mis got %0h/%0h exp 0/0",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    idle();
    if_pc = 9'h030;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0) begin
      $display("FAIL inv_look got %0h exp 0", if_pred_taken); nerr++;
    end
    nvec++;
    if (branch_count !== 32'd10 || mispredict_count !== 32'd8) begin
      $display("FAIL inv_cnt got %0d/%0d exp 10/8",
               branch_count, mispredict_count); nerr++;
    end
  endtask

  task automatic test_same_cycle_and_reset();
    @(negedge clk);
    if_pc = 9'h020;
    drive(1'b1, 9'h020, 1'b1, 1'b1, 32'h0, 32'h201, 1'b0, 32'h0);
    #1;
    nvec++;
    if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h106) begin
      $display("FAIL sc_old got %0h/%0h exp 1/106",
               if_pred_taken, if_pred_target); nerr++;
    end
    nvec++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h200) begin
      $display("FAIL sc_mis got %0h/%0h exp 1/200",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(posedge clk);
    #1;
    nvec++;
    if (if_pred_target !== 32'h200) begin
      $display("FAIL sc_new got %0h exp 200", if_pred_target); nerr++;
    end
    nvec++;
    if (branch_count !== 32'd11 || mispredict_count !== 32'd9) begin
      $display("FAIL sc_cnt got %0d/%0d exp 11/9",
               branch_count, mispredict_count); nerr++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
      $display("FAIL ar_look got %0h/%0h exp 0/0",
               if_pred_taken, if_pred_target); nerr++;
    end
    nvec++;
    if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
      $display("FAIL ar_cnt got %0d/%0d exp 0/0",
               branch_count, mispredict_count); nerr++;
    end
    idle();
    #1;
    nvec++;
    if (ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'h0) begin
      $display("FAIL ar_mis got %0h/%0h exp 0/0",
               ex_mispredict, ex_redirect_pc); nerr++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    if_pc = 9'h110;
    #1;
    nvec++;
    if (if_pred_taken !== 1'b0) begin
      $display("FAIL ar_clear got %0h exp 0", if_pred_taken); nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_jump();
    test_alias();
    test_no_update();
    test_same_cycle_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
